// File: rtl/arb_pkg.sv
// Shared types and default constants for the round-robin arbiter.
package arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    localparam int ARB_N        = 8;
    localparam int ARB_MAX_HOLD = 16;

endpackage

// File: rtl/masked_prio_enc.sv
// Find-first-set starting at ptr with wrap-around: lowest set bit at or above
// ptr wins, otherwise the lowest set bit of the whole vector.
module masked_prio_enc #(
    parameter int N   = 8,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [IDW-1:0] idx,
    output logic           found
);

    logic [IDW-1:0] idx_m;
    logic [IDW-1:0] idx_u;
    logic           hit_m;

    always_comb begin
        idx_m = '0;
        idx_u = '0;
        hit_m = 1'b0;
        // Scan from the top down so the lowest matching index is the last written.
        for (int unsigned i = 0; i < N; i++) begin
            if (req[N-1-i]) begin
                idx_u = IDW'(N - 1 - i);
                if (IDW'(N - 1 - i) >= ptr) begin
                    idx_m = IDW'(N - 1 - i);
                    hit_m = 1'b1;
                end
            end
        end
    end

    assign idx   = hit_m ? idx_m : idx_u;
    assign found = |req;

endmodule

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter with grant hold until release.
// Define ARB_TIMEOUT_EN to build the MAX_HOLD forced-revoke feature.
module round_robin_arbiter
    import arb_pkg::*;
#(
    parameter int N        = ARB_N,
    parameter int IDW      = $clog2(N),
    parameter int MAX_HOLD = ARB_MAX_HOLD
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_valid,
    output logic           timeout
);

    if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_n
        $error("N must be a power of two >= 2");
    end
    if (MAX_HOLD < 2) begin : g_bad_hold
        $error("MAX_HOLD must be >= 2");
    end

    arb_state_t     state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] id_q, id_d;
    logic           valid_q, valid_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [N-1:0]   enc_req;
    logic [IDW-1:0] win;
    logic           found;
    logic           do_grant;
    logic           do_clear;

`ifdef ARB_TIMEOUT_EN
    localparam int HCW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    logic [HCW-1:0] hold_q, hold_d;
    logic           to_q, to_d;
`endif

    // The outgoing owner is masked out so a handoff never re-selects it.
    assign enc_req = (state_q == ARB_GRANT) ? (req & ~gnt_q) : req;

    masked_prio_enc #(
        .N   (N),
        .IDW (IDW)
    ) u_enc (
        .req   (enc_req),
        .ptr   (ptr_q),
        .idx   (win),
        .found (found)
    );

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        id_d     = id_q;
        valid_d  = valid_q;
        ptr_d    = ptr_q;
        do_grant = 1'b0;
        do_clear = 1'b0;
`ifdef ARB_TIMEOUT_EN
        hold_d   = hold_q;
        to_d     = 1'b0;
`endif
        unique case (state_q)
            ARB_IDLE: begin
                do_grant = found;
            end
            ARB_GRANT: begin
                if (!req[id_q]) begin
                    do_grant = found;
                    do_clear = !found;
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_q == HCW'(MAX_HOLD - 1)) begin
                    // Forced revoke: skip past the owner and spend one cycle idle.
                    do_clear = 1'b1;
                    to_d     = 1'b1;
                    ptr_d    = id_q + IDW'(1);
                end else begin
                    hold_d = hold_q + HCW'(1);
                end
`endif
            end
            default: begin
                do_clear = 1'b1;
            end
        endcase

        if (do_grant) begin
            state_d = ARB_GRANT;
            gnt_d   = N'(1) << win;
            id_d    = win;
            valid_d = 1'b1;
            ptr_d   = win + IDW'(1);
`ifdef ARB_TIMEOUT_EN
            hold_d  = '0;
`endif
        end else if (do_clear) begin
            state_d = ARB_IDLE;
            gnt_d   = '0;
            id_d    = '0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
            to_q   <= 1'b0;
        end else begin
            hold_q <= hold_d;
            to_q   <= to_d;
        end
    end

    assign timeout = to_q;
`else
    assign timeout = 1'b0;
`endif

    assign gnt       = gnt_q;
    assign gnt_id    = id_q;
    assign gnt_valid = valid_q;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Scoreboard bench for round_robin_arbiter; covers both builds of ARB_TIMEOUT_EN.
module tb_round_robin_arbiter;

    localparam int N        = 8;
    localparam int IDW      = 3;
    localparam int MAX_HOLD = 16;

    typedef struct {
        int             tag;
        logic [N-1:0]   gnt;
        logic [IDW-1:0] id;
        logic           valid;
        logic           to;
    } exp_t;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           gnt_valid;
    logic           timeout;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   step_no  = 0;

    round_robin_arbiter #(
        .N        (N),
        .IDW      (IDW),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive req before an edge and queue the outputs expected after that edge.
    task automatic step(input logic [N-1:0] r, input logic [N-1:0] eg,
                        input logic [IDW-1:0] eid, input logic eto);
        exp_t e;
        @(negedge clk);
        req     = r;
        e.tag   = step_no;
        e.gnt   = eg;
        e.id    = eid;
        e.valid = (eg != '0);
        e.to    = eto;
        q.push_back(e);
        step_no++;
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (gnt !== '0 || gnt_id !== '0 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL %s got gnt=%h id=%0d v=%b to=%b required all zero",
                     name, gnt, gnt_id, gnt_valid, timeout);
        end
    endtask

    // Monitor: every cycle the DUT presents a registered output; compare it
    // against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (gnt !== e.gnt || gnt_id !== e.id || gnt_valid !== e.valid ||
                    timeout !== e.to) begin
                    failures++;
                    $display("FAIL step%0d got gnt=%h id=%0d v=%b to=%b required gnt=%h id=%0d v=%b to=%b",
                             e.tag, gnt, gnt_id, gnt_valid, timeout, e.gnt, e.id, e.valid, e.to);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        req   = '0;
        #3;
        check_idle("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        // First grant from reset, then asynchronous reset mid-grant.
        step(8'h01, 8'h01, 3'd0, 1'b0);
        step(8'h01, 8'h01, 3'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        #1;
        check_idle("async_reset_mid_grant");
        @(negedge clk);
        rst_n = 1'b1;
        step(8'h00, 8'h00, 3'd0, 1'b0);

        // All requesting: each owner holds two cycles, hands off with no bubble.
        step(8'hFF, 8'h01, 3'd0, 1'b0);
        for (int unsigned i = 0; i < 8; i++) begin
            step(8'hFF, N'(1) << i, IDW'(i), 1'b0);
            step(8'hFF & ~(N'(1) << i), N'(1) << ((i + 1) % 8), IDW'((i + 1) % 8), 1'b0);
        end
        step(8'h00, 8'h00, 3'd0, 1'b0);

        // Owner 7 leaves ptr at 0; on release the search wraps to requester 2.
        step(8'h80, 8'h80, 3'd7, 1'b0);
        step(8'h84, 8'h80, 3'd7, 1'b0);
        step(8'h04, 8'h04, 3'd2, 1'b0);

        // Owner 3 holds while 5 and 1 arrive; 5 then 1 in rotation order.
        step(8'h08, 8'h08, 3'd3, 1'b0);
        step(8'h08, 8'h08, 3'd3, 1'b0);
        step(8'h2A, 8'h08, 3'd3, 1'b0);
        step(8'h2A, 8'h08, 3'd3, 1'b0);
        step(8'h22, 8'h20, 3'd5, 1'b0);
        step(8'h02, 8'h02, 3'd1, 1'b0);
        // Owner 1 releases in the same cycle 6 first requests.
        step(8'h40, 8'h40, 3'd6, 1'b0);
        step(8'h00, 8'h00, 3'd0, 1'b0);

        // Sole long-holding requester 4 (ptr=7, so the fallback half wins).
        step(8'h10, 8'h10, 3'd4, 1'b0);
`ifdef ARB_TIMEOUT_EN
        for (int unsigned i = 1; i < MAX_HOLD; i++) begin
            step(8'h10, 8'h10, 3'd4, 1'b0);
        end
        step(8'h10, 8'h00, 3'd0, 1'b1);
        step(8'h10, 8'h10, 3'd4, 1'b0);
        step(8'h10, 8'h10, 3'd4, 1'b0);
`else
        for (int unsigned i = 0; i < 110; i++) begin
            step(8'h10, 8'h10, 3'd4, 1'b0);
        end
`endif
        step(8'h00, 8'h00, 3'd0, 1'b0);

        @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain got pending=%0d required 0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/round_robin_arbiter.md
# round_robin_arbiter

Round-robin arbiter sharing one downstream resource among N requesters. It rotates priority using a masked fixed-priority encoder and holds each grant until the owner releases its request. It sits in front of any single-ported datapath, such as a shared bus or encoder, in the same design.

## Interface
- N, 8, number of requesters; must be a power of two, ≥2
- IDW, $clog2(N), width of the grant index
- MAX_HOLD, 16, maximum grant length in cycles; used only when the timeout feature is compiled in; must be ≥2
- clk  input  1  rising-edge clock; the only clock
- rst_n  input  1  asynchronous, active-low reset
- req  input  N  request vector; req[i] held high by requester i while it wants or owns the resource
- gnt  output  N  registered one-hot grant; all zeros when idle
- gnt_id  output  IDW  binary index of the current owner; 0 when idle
- gnt_valid  output  1  high while any grant is held
- timeout  output  1  one-cycle pulse on a forced revoke; tied 0 when the feature is compiled out

## Operation
- Reset values: gnt=0, gnt_id=0, gnt_valid=0, timeout=0, ptr=0 (requester 0 has highest priority first), state IDLE, hold counter 0.
- FSM states:
  - IDLE: no owner. If req≠0, grant the winner and go to GRANT.
  - GRANT: owner k holds while req[k]=1.
    - When req[k]=0 and other requests exist: hand off directly to the next winner, with no idle bubble; stay in GRANT.
    - When req[k]=0 and no other requests exist: go to IDLE.
- Winner selection:
  - Search starts at index ptr and wraps modulo N; the first set bit wins.
  - Implemented as a mask req & ~((1<<ptr)-1), with fallback to unmasked req if the masked vector is zero. Lowest index wins in each half.
  - The outgoing owner's bit is excluded during a handoff.
- Pointer update: on every new grant to index w, ptr ← (w+1) mod N. Wrap-around: a grant to N-1 sets ptr=0.
- gnt, gnt_id and gnt_valid always change together and stay mutually consistent.
- Requests from non-owners never disturb the current grant.
- Simultaneous release by the owner and new request by another requester in the same cycle: the new requester is eligible immediately.
- Reset asserted mid-grant: all outputs clear immediately, asynchronously; no grant survives.

## Timing
- Grant latency: req rising in cycle t (sampled at edge t+1) → gnt valid after edge t+1, i.e. 1 cycle.
- Release: req[k] low sampled at edge e → gnt[k] low after edge e. Any successor's gnt bit is high after the same edge.
- Maximum wait for a requester holding req continuously: N-1 complete grants of other requesters (fairness bound). Without the timeout feature, this bound assumes owners release.

## Configuration
- ARB_TIMEOUT_EN defined:
  - The hold counter increments each cycle in GRANT and resets on each new grant.
  - When the counter reaches MAX_HOLD-1 with req[k] still high:
    - gnt is revoked at the next edge and timeout pulses for that cycle.
    - ptr ← k+1 and the FSM goes to IDLE for exactly one cycle, then arbitrates normally.
    - A sole requester k is re-granted after this one-cycle gap.
- ARB_TIMEOUT_EN undefined:
  - No counter is built, timeout=0 constantly, and MAX_HOLD is ignored.
  - An owner holds the grant indefinitely.

## Structure
- Shared package arb_pkg holds:
  - the state typedef arb_state_t {ARB_IDLE, ARB_GRANT}
  - default constants ARB_N=8 and ARB_MAX_HOLD=16
- Sub-module masked_prio_enc contains the combinational find-first-set from ptr with wrap. It outputs the winner index and a found flag, and is instantiated once.
- The FSM, pointer, counter and output registers live in the top level.

## Test plan
- Reset then req=8'b0000_0001 → one cycle later gnt=8'h01, gnt_id=0, gnt_valid=1, ptr=1; with rst_n pulsed low mid-grant → all outputs 0 immediately.
- req=8'hFF held, each owner dropping its bit after 2 cycles then reasserting → grant order 0,1,2,…,7,0 with no idle cycle between handoffs.
- Owner 7 granted (ptr=0 after the grant), releases while req=8'b1000_0100 → next gnt=8'h04 (wrap honoured), gnt_id=2.
- Owner 3 holds, req[5] and req[1] rise mid-grant → gnt unchanged; on release, 5 is granted before 1.
- ARB_TIMEOUT_EN, MAX_HOLD=16, req=8'h10 held → gnt=8'h10 for 16 cycles, then timeout=1 and gnt=0 for one cycle, then gnt=8'h10 again.
- ARB_TIMEOUT_EN undefined, same stimulus → gnt=8'h10 held for 100+ cycles and timeout stays 0.
